cache_nway: RTL and testbench

CACHE_NWAY -- requirements
Module: cache_nway

---
 rtl/lc3b_types.sv | 30 +++
 rtl/cache_way.sv | 81 ++++++++
 rtl/cache_nway.sv | 257 +++++++++++++++++++++++++
 tb/tb_cache_nway.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared types for the LC-3b n-way write-back cache: bus word and line types,
// line geometry, cache sizing helpers and the controller state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [1:0]   lc3b_mem_wmask;
  typedef logic [127:0] lc3b_pmem_line;
  typedef logic [15:0]  lc3b_pmem_addr;

  localparam int LC3B_ADDR_W     = 16;
  localparam int LC3B_OFFSET_W   = 4;
  localparam int LC3B_LINE_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE_CMP  = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_e;

  // Index width for a given number of sets.
  function automatic int lc3b_cache_index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  // Tag width: whatever address bits remain above index and line offset.
  function automatic int lc3b_cache_tag_w(input int num_sets);
    return LC3B_ADDR_W - LC3B_OFFSET_W - $clog2(num_sets);
  endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: line data, tag, valid and dirty storage for every set.
// A single index serves both the combinational read and the write port; a
// fill replaces the whole line (valid, clean), a CPU write merges byte lanes
// and marks the line dirty. Only valid/dirty are cleared by reset.
module cache_way
  import lc3b_types::*;
#(
  parameter  int NUM_SETS = 8,
  parameter  int TAG_W    = 9,
  localparam int IDX_W    = $clog2(NUM_SETS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [IDX_W-1:0]           index,
  input  logic                       fill_en,
  input  logic [TAG_W-1:0]           fill_tag,
  input  lc3b_pmem_line              fill_data,
  input  logic                       wr_en,
  input  logic [LC3B_LINE_BYTES-1:0] wr_mask,
  input  lc3b_pmem_line              wr_data,
  output lc3b_pmem_line              rd_data,
  output logic [TAG_W-1:0]           rd_tag,
  output logic                       rd_valid,
  output logic                       rd_dirty
);

  lc3b_pmem_line       data_q [NUM_SETS];
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0] dirty_q, dirty_d;
  lc3b_pmem_line       line_d;
  logic [TAG_W-1:0]    tag_d;
  logic                line_we;

  assign rd_data  = data_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];

  // Build the new line/tag/status for the addressed set; fill wins over write.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    line_d  = data_q[index];
    tag_d   = tag_q[index];
    line_we = 1'b0;
    if (fill_en) begin
      line_d         = fill_data;
      tag_d          = fill_tag;
      valid_d[index] = 1'b1;
      dirty_d[index] = 1'b0;
      line_we        = 1'b1;
    end else if (wr_en) begin
      for (int b = 0; b < LC3B_LINE_BYTES; b++) begin
        if (wr_mask[b]) line_d[8*b +: 8] = wr_data[8*b +: 8];
      end
      dirty_d[index] = 1'b1;
      line_we        = 1'b1;
    end
  end

  // Status bits: cleared on reset so every set starts empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Line and tag storage: not reset, contents are meaningless until valid.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_q[index] <= line_d;
      tag_q[index]  <= tag_d;
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back, write-allocate cache for the LC-3b.
// 16-byte lines, tree-PLRU replacement, three-state miss controller
// (IDLE_CMP / WRITEBACK / ALLOCATE); dbg_state exposes the controller state.
// Optional: define CACHE_PERF_CNT_EN to add saturating hit_count/miss_count.
//
// CPU handshake: mem_read/mem_write are held by the CPU until mem_resp; a hit
// answers combinationally in the same cycle and the request is consumed at
// that clock edge. A miss is answered one cycle after the fill's pmem_resp.
// pmem_read/pmem_write stay high until pmem_resp and never overlap.
module cache_nway
  import lc3b_types::*;
#(
  parameter int NUM_WAYS = 2,
  parameter int NUM_SETS = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  input  lc3b_mem_wmask mem_byte_enable,
  output lc3b_word      mem_rdata,
  output logic          mem_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_pmem_addr pmem_address,
  output lc3b_pmem_line pmem_wdata,
  input  lc3b_pmem_line pmem_rdata,
  input  logic          pmem_resp,
  output logic [1:0]    dbg_state
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
`endif
);

  localparam int IDX_W  = lc3b_cache_index_w(NUM_SETS);
  localparam int TAG_W  = lc3b_cache_tag_w(NUM_SETS);
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int PLRU_W = NUM_WAYS - 1;

  cache_state_e        state_q, state_d;
  logic [WAY_W-1:0]    victim_q, victim_d;
  logic [TAG_W-1:0]    miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]    miss_idx_q, miss_idx_d;
  logic [PLRU_W-1:0]   plru_q [NUM_SETS];
  logic [PLRU_W-1:0]   plru_d [NUM_SETS];

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx, way_idx;
  logic [2:0]          word_sel;
  logic                unused_addr_bit;

  lc3b_pmem_line       way_rdata [NUM_WAYS];
  logic [TAG_W-1:0]    way_tag   [NUM_WAYS];
  logic [NUM_WAYS-1:0] way_valid, way_dirty, fill_en, wr_en;
  logic [LC3B_LINE_BYTES-1:0] wr_mask;
  lc3b_pmem_line       wr_line;
  logic                any_hit, any_invalid;
  logic [WAY_W-1:0]    hit_way, inv_way, plru_way;

  assign req_tag         = mem_address[LC3B_ADDR_W-1 -: TAG_W];
  assign req_idx         = mem_address[LC3B_OFFSET_W +: IDX_W];
  assign word_sel        = mem_address[3:1];
  assign unused_addr_bit = mem_address[0];
  assign dbg_state       = state_q;

  // While a miss is outstanding the ways stay pointed at the latched set.
  assign way_idx = (state_q == IDLE_CMP) ? req_idx : miss_idx_q;

  // Walk the PLRU tree following the bits; each bit points toward the victim.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] tree);
    int               node;
    logic             bit_v;
    logic [WAY_W-1:0] way;
    node = 0;
    way  = '0;
    for (int l = 0; l < WAY_W; l++) begin
      bit_v = tree[node];
      way   = WAY_W'({way, bit_v});
      node  = 2 * node + 1 + int'(bit_v);
    end
    return way;
  endfunction

  // Flip every node on the accessed way's path to point at the other subtree.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] tree,
                                                   input logic [WAY_W-1:0]  way);
    int                node;
    logic              dir;
    logic [PLRU_W-1:0] t;
    t    = tree;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      dir     = way[WAY_W-1-l];
      t[node] = ~dir;
      node    = 2 * node + 1 + int'(dir);
    end
    return t;
  endfunction

  genvar g;
  generate
    for (g = 0; g < NUM_WAYS; g++) begin : g_way
      cache_way #(
        .NUM_SETS (NUM_SETS),
        .TAG_W    (TAG_W)
      ) u_way (
        .clk       (clk),
        .reset     (reset),
        .index     (way_idx),
        .fill_en   (fill_en[g]),
        .fill_tag  (miss_tag_q),
        .fill_data (pmem_rdata),
        .wr_en     (wr_en[g]),
        .wr_mask   (wr_mask),
        .wr_data   (wr_line),
        .rd_data   (way_rdata[g]),
        .rd_tag    (way_tag[g]),
        .rd_valid  (way_valid[g]),
        .rd_dirty  (way_dirty[g])
      );
    end
  endgenerate

  // Place the CPU word and its byte enables on the addressed lanes of a line.
  always_comb begin
    wr_mask = '0;
    wr_mask[{word_sel, 1'b0} +: 2] = mem_byte_enable;
    wr_line = {8{mem_wdata}};
  end

  // Tag compare plus the victim candidates (lowest invalid way, PLRU way).
  always_comb begin
    any_hit     = 1'b0;
    hit_way     = '0;
    any_invalid = 1'b0;
    inv_way     = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (way_valid[w] && (way_tag[w] == req_tag)) begin
        any_hit = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!way_valid[w]) begin
        any_invalid = 1'b1;
        inv_way     = WAY_W'(w);
      end
    end
    plru_way = plru_victim(plru_q[way_idx]);
  end

  // Controller next state and outputs; reset forces every strobe low.
  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    miss_tag_d   = miss_tag_q;
    miss_idx_d   = miss_idx_q;
    plru_d       = plru_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {miss_tag_q, miss_idx_q, 4'b0000};
    pmem_wdata   = way_rdata[victim_q];
    fill_en      = '0;
    wr_en        = '0;
    unique case (state_q)
      IDLE_CMP: begin
        if (mem_read || mem_write) begin
          if (any_hit) begin
            mem_resp        = 1'b1;
            plru_d[req_idx] = plru_touch(plru_q[req_idx], hit_way);
            if (mem_write) wr_en[hit_way] = 1'b1;
            else mem_rdata = way_rdata[hit_way][{word_sel, 4'b0000} +: 16];
          end else begin
            victim_d   = any_invalid ? inv_way : plru_way;
            miss_tag_d = req_tag;
            miss_idx_d = req_idx;
            state_d    = way_dirty[victim_d] ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {way_tag[victim_q], miss_idx_q, 4'b0000};
        if (pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          fill_en[victim_q] = 1'b1;
          state_d           = IDLE_CMP;
        end
      end
      default: state_d = IDLE_CMP;
    endcase
    if (reset) begin
      mem_resp   = 1'b0;
      mem_rdata  = '0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      fill_en    = '0;
      wr_en      = '0;
    end
  end

  // Controller state, latched miss context and PLRU trees.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE_CMP;
      victim_q   <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
    end else begin
      state_q    <= state_d;
      victim_q   <= victim_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      plru_q     <= plru_d;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic        after_fill_q, after_fill_d;

  // The response right after a fill belongs to that miss, not to a hit.
  always_comb begin
    after_fill_d = (state_q == ALLOCATE) && pmem_resp;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (mem_resp && !after_fill_q && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + 32'd1;
    if ((state_q == IDLE_CMP) && (state_d != IDLE_CMP) && (miss_cnt_q != '1))
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      after_fill_q <= 1'b0;
    end else begin
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      after_fill_q <= after_fill_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway: a 2-way/8-set instance (index 0) and a
// 4-way/8-set instance (index 1), each with its own physical-memory model.
module tb_cache_nway;
  import lc3b_types::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst, rd, wr, resp, p_rd, p_wr, p_resp, hold;
  logic [1:0][15:0]  addr, wdata, rdata, p_addr;
  logic [1:0][1:0]   be, dbg;
  logic [1:0][127:0] p_wdata, p_rdata;
`ifdef CACHE_PERF_CNT_EN
  logic [1:0][31:0]  hc, mc;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  cache_nway #(.NUM_WAYS(2), .NUM_SETS(8)) u_dut2 (
    .clk(clk), .reset(rst[0]), .mem_read(rd[0]), .mem_write(wr[0]),
    .mem_address(addr[0]), .mem_wdata(wdata[0]), .mem_byte_enable(be[0]),
    .mem_rdata(rdata[0]), .mem_resp(resp[0]), .pmem_read(p_rd[0]),
    .pmem_write(p_wr[0]), .pmem_address(p_addr[0]), .pmem_wdata(p_wdata[0]),
    .pmem_rdata(p_rdata[0]), .pmem_resp(p_resp[0]), .dbg_state(dbg[0])
`ifdef CACHE_PERF_CNT_EN
    , .hit_count(hc[0]), .miss_count(mc[0])
`endif
  );

  cache_nway #(.NUM_WAYS(4), .NUM_SETS(8)) u_dut4 (
    .clk(clk), .reset(rst[1]), .mem_read(rd[1]), .mem_write(wr[1]),
    .mem_address(addr[1]), .mem_wdata(wdata[1]), .mem_byte_enable(be[1]),
    .mem_rdata(rdata[1]), .mem_resp(resp[1]), .pmem_read(p_rd[1]),
    .pmem_write(p_wr[1]), .pmem_address(p_addr[1]), .pmem_wdata(p_wdata[1]),
    .pmem_rdata(p_rdata[1]), .pmem_resp(p_resp[1]), .dbg_state(dbg[1])
`ifdef CACHE_PERF_CNT_EN
    , .hit_count(hc[1]), .miss_count(mc[1])
`endif
  );

  // Untouched memory: each 16-bit word holds its own byte address.
  function automatic logic [127:0] line_of(input logic [11:0] l);
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[16*k +: 16] = {l, 4'b0000} + 16'(2 * k);
    return r;
  endfunction

  bit [127:0] mem   [2][4096];
  bit         wflag [2][4096];
  int         cnt   [2];

  // Physical memory: answers any strobe after two cycles with a one-cycle pmem_resp.
  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      p_resp[s] <= 1'b0;
      if (rst[s] || hold[s] || p_resp[s] || !(p_rd[s] || p_wr[s])) begin
        cnt[s] = 0;
      end else begin
        cnt[s] = cnt[s] + 1;
        if (cnt[s] == 2) begin
          cnt[s]    = 0;
          p_resp[s] <= 1'b1;
          if (p_wr[s]) begin
            mem[s][p_addr[s][15:4]]   <= p_wdata[s];
            wflag[s][p_addr[s][15:4]] <= 1'b1;
          end else begin
            p_rdata[s] <= wflag[s][p_addr[s][15:4]] ? mem[s][p_addr[s][15:4]]
                                                    : line_of(p_addr[s][15:4]);
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobes never overlap, and no response while a miss is in flight.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (!rst[s]) begin
        check($sformatf("strobe_excl%0d", s), {126'd0, p_rd[s] && p_wr[s]}, 128'd0);
        check($sformatf("no_resp_in_miss%0d", s), {126'd0, resp[s] && (dbg[s] != 2'd0)}, 128'd0);
      end
    end
  end

  task automatic drive(input int s, input logic we, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] b);
    rd[s] = !we; wr[s] = we; addr[s] = a; wdata[s] = d; be[s] = b;
  endtask

  task automatic idle(input int s);
    rd[s] = 1'b0; wr[s] = 1'b0;
  endtask

  task automatic do_reset(input int s);
    idle(s);
    rst[s] = 1'b1;
    @(negedge clk);
    #1;
    check("rst_resp",  resp[s],  0);
    check("rst_prd",   p_rd[s],  0);
    check("rst_pwr",   p_wr[s],  0);
    check("rst_rdata", rdata[s], 0);
    @(negedge clk);
    rst[s] = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_presp(input int s, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (p_resp[s]) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, " pmem_resp_timeout"}, seen, 1);
  endtask

  // Request expected to hit: same-cycle response.
  task automatic cpu_hit(input int s, input logic we, input logic [15:0] a, input logic [15:0] d,
                         input logic [1:0] b, input logic [15:0] exp_rd, input string tag);
    drive(s, we, a, d, b);
    #1;
    check({tag, " resp"}, resp[s], 1);
    if (!we) check({tag, " rdata"}, rdata[s], exp_rd);
    @(negedge clk);
    idle(s);
    @(negedge clk);
  endtask

  // Request expected to miss: optional writeback, then fill, then response.
  task automatic cpu_miss(input int s, input logic we, input logic [15:0] a, input logic [15:0] d,
                          input logic [1:0] b, input logic exp_wb, input logic [15:0] wb_addr,
                          input logic [127:0] wb_line, input logic [15:0] fill_addr,
                          input logic [15:0] exp_rd, input string tag);
    drive(s, we, a, d, b);
    #1;
    check({tag, " no_hit_resp"}, resp[s], 0);
    @(negedge clk);
    if (exp_wb) begin
      check({tag, " wb_pwr"},   p_wr[s],    1);
      check({tag, " wb_prd"},   p_rd[s],    0);
      check({tag, " wb_addr"},  p_addr[s],  wb_addr);
      check({tag, " wb_line"},  p_wdata[s], wb_line);
      wait_presp(s, tag);
      @(negedge clk);
    end
    check({tag, " fill_prd"},  p_rd[s],   1);
    check({tag, " fill_pwr"},  p_wr[s],   0);
    check({tag, " fill_addr"}, p_addr[s], fill_addr);
    check({tag, " miss_resp_low"}, resp[s], 0);
    wait_presp(s, tag);
    @(negedge clk);
    check({tag, " resp"}, resp[s], 1);
    if (!we) check({tag, " rdata"}, rdata[s], exp_rd);
    @(negedge clk);
    idle(s);
    @(negedge clk);
  endtask

  initial begin
    rst = 2'b11; rd = '0; wr = '0; hold = '0;
    addr = '0; wdata = '0; be = '0;
    repeat (2) @(negedge clk);
    do_reset(0);
    do_reset(1);

    // Cold read miss, then write hits with byte lanes.
    cpu_miss(0, 0, 16'h1234, 16'h0, 2'b00, 0, 16'h0, 128'h0, 16'h1230, 16'h1234, "cold_rd");
    cpu_hit(0, 0, 16'h1234, 16'h0,    2'b00, 16'h1234, "rd_hit");
    cpu_hit(0, 1, 16'h1234, 16'hAAAA, 2'b11, 16'h0,    "wr_full");
    cpu_hit(0, 1, 16'h1234, 16'hBEEF, 2'b01, 16'h0,    "wr_lo");
    cpu_hit(0, 0, 16'h1234, 16'h0,    2'b00, 16'hAAEF, "rd_after_lo");
    cpu_hit(0, 1, 16'h1234, 16'h1200, 2'b10, 16'h0,    "wr_hi");
    cpu_hit(0, 0, 16'h1234, 16'h0,    2'b00, 16'h12EF, "rd_after_hi");
    cpu_hit(0, 0, 16'h1236, 16'h0,    2'b00, 16'h1236, "rd_neighbor");
    // Both strobes high is a write.
    rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h1236; wdata[0] = 16'h7777; be[0] = 2'b11;
    #1;
    check("rdwr resp", resp[0], 1);
    @(negedge clk);
    idle(0);
    @(negedge clk);
    cpu_hit(0, 0, 16'h1236, 16'h0, 2'b00, 16'h7777, "rd_after_rdwr");

    // Reset invalidates: the same line misses again.
    do_reset(0);
    cpu_miss(0, 0, 16'h1234, 16'h0, 2'b00, 0, 16'h0, 128'h0, 16'h1230, 16'h1234, "post_rst_rd");

    // Dirty eviction at index 3.
    do_reset(0);
    cpu_miss(0, 1, 16'h0030, 16'h5A5A, 2'b11, 0, 16'h0, 128'h0, 16'h0030, 16'h0, "ev_wr30");
    cpu_miss(0, 0, 16'h0230, 16'h0, 2'b00, 0, 16'h0, 128'h0, 16'h0230, 16'h0230, "ev_rd230");
    cpu_hit(0, 0, 16'h0230, 16'h0, 2'b00, 16'h0230, "ev_rd230_hit");
    cpu_miss(0, 0, 16'h0430, 16'h0, 2'b00, 1, 16'h0030,
             128'h003E_003C_003A_0038_0036_0034_0032_5A5A, 16'h0430, 16'h0430, "ev_rd430");
    cpu_miss(0, 0, 16'h0030, 16'h0, 2'b00, 0, 16'h0, 128'h0, 16'h0030, 16'h5A5A, "ev_rd30_back");

    // Reset while ALLOCATE is waiting on memory.
    hold[0] = 1'b1;
    drive(0, 0, 16'h0540, 16'h0, 2'b00);
    @(negedge clk);
    check("rst_alloc prd_before", p_rd[0], 1);
    check("rst_alloc addr", p_addr[0], 16'h0540);
    rst[0] = 1'b1;
    idle(0);
    @(negedge clk);
    rst[0] = 1'b0;
    hold[0] = 1'b0;
    #1;
    check("rst_alloc prd_after", p_rd[0], 0);
    check("rst_alloc state", dbg[0], 2'd0);
    @(negedge clk);
    cpu_miss(0, 0, 16'h0540, 16'h0, 2'b00, 0, 16'h0, 128'h0, 16'h0540, 16'h0540, "rst_alloc_remiss");

    // Tree-PLRU on 4 ways, set 1: fill A..D, touch A and C, next miss evicts B.
    cpu_miss(1, 0, 16'h0010, 16'h0, 2'b00, 0, 16'h0, 128'h0, 16'h0010, 16'h0010, "plru_A");
    cpu_miss(1, 0, 16'h0110, 16'h0, 2'b00, 0, 16'h0, 128'h0, 16'h0110, 16'h0110, "plru_B");
    cpu_miss(1, 0, 16'h0210, 16'h0, 2'b00, 0, 16'h0, 128'h0, 16'h0210, 16'h0210, "plru_C");
    cpu_miss(1, 0, 16'h0310, 16'h0, 2'b00, 0, 16'h0, 128'h0, 16'h0310, 16'h0310, "plru_D");
    cpu_hit(1, 0, 16'h0010, 16'h0, 2'b00, 16'h0010, "plru_hitA");
    cpu_hit(1, 0, 16'h0210, 16'h0, 2'b00, 16'h0210, "plru_hitC");
    cpu_miss(1, 0, 16'h0410, 16'h0, 2'b00, 0, 16'h0, 128'h0, 16'h0410, 16'h0410, "plru_E");
    cpu_hit(1, 0, 16'h0010, 16'h0, 2'b00, 16'h0010, "plru_A_kept");
    cpu_hit(1, 0, 16'h0210, 16'h0, 2'b00, 16'h0210, "plru_C_kept");
    cpu_hit(1, 0, 16'h0310, 16'h0, 2'b00, 16'h0310, "plru_D_kept");
    cpu_miss(1, 0, 16'h0110, 16'h0, 2'b00, 0, 16'h0, 128'h0, 16'h0110, 16'h0110, "plru_B_gone");

`ifdef CACHE_PERF_CNT_EN
    do_reset(0);
    check("perf hit_rst",  hc[0], 0);
    check("perf miss_rst", mc[0], 0);
    cpu_miss(0, 0, 16'h0050, 16'h0, 2'b00, 0, 16'h0, 128'h0, 16'h0050, 16'h0050, "perf_m1");
    cpu_miss(0, 0, 16'h0060, 16'h0, 2'b00, 0, 16'h0, 128'h0, 16'h0060, 16'h0060, "perf_m2");
    cpu_miss(0, 0, 16'h0070, 16'h0, 2'b00, 0, 16'h0, 128'h0, 16'h0070, 16'h0070, "perf_m3");
    cpu_hit(0, 0, 16'h0050, 16'h0, 2'b00, 16'h0050, "perf_h1");
    cpu_hit(0, 0, 16'h0060, 16'h0, 2'b00, 16'h0060, "perf_h2");
    cpu_hit(0, 0, 16'h0070, 16'h0, 2'b00, 16'h0070, "perf_h3");
    cpu_hit(0, 0, 16'h0052, 16'h0, 2'b00, 16'h0052, "perf_h4");
    cpu_hit(0, 0, 16'h0054, 16'h0, 2'b00, 16'h0054, "perf_h5");
    check("perf miss_count", mc[0], 3);
    check("perf hit_count",  hc[0], 5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
